// File: rtl/piso_pkg.sv
//------------------------------------------------------------------------------
// Module   : piso_pkg
// Purpose  : Shared types, defaults and index helpers for the PISO word
//            sequencer and its select counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package piso_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SEL_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  // First bit index of a word: bit 0 when LSB first, otherwise the top bit.
  function automatic int start_idx(input bit lsb_first, input int width = WIDTH_DEF);
    return lsb_first ? 0 : width - 1;
  endfunction

  // Last bit index of a word: the top bit when LSB first, otherwise bit 0.
  function automatic int end_idx(input bit lsb_first, input int width = WIDTH_DEF);
    return lsb_first ? width - 1 : 0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/piso_sel_counter.sv
//------------------------------------------------------------------------------
// Module   : piso_sel_counter
// Purpose  : Loadable up/down select counter. Load returns to the start index,
//            enable steps one position toward the end index, at_end flags the
//            final position of the word.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module piso_sel_counter
  import piso_pkg::*;
#(
  parameter int SEL_W     = SEL_W_DEF,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  output logic [SEL_W-1:0] sel,
  output logic             at_end
);

  localparam logic [SEL_W-1:0] START = SEL_W'(start_idx(LSB_FIRST != 0, 2 ** SEL_W));
  localparam logic [SEL_W-1:0] STOP  = SEL_W'(end_idx(LSB_FIRST != 0, 2 ** SEL_W));
  localparam logic [SEL_W-1:0] STEP  = SEL_W'(1);

  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;

  // Next select: load wins over stepping; the caller never steps past the end.
  always_comb begin
    sel_d = sel_q;
    if (load) begin
      sel_d = START;
    end else if (en) begin
      sel_d = (LSB_FIRST != 0) ? sel_q + STEP : sel_q - STEP;
    end
  end

  // Select register, parked at the start index out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= START;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign sel    = sel_q;
  assign at_end = (sel_q == STOP);

endmodule

`default_nettype wire

// File: rtl/piso_word_sequencer.sv
//------------------------------------------------------------------------------
// Module   : piso_word_sequencer
// Purpose  : Holds a loaded word on the 32:1 mux data inputs and steps the mux
//            select through every bit, framing the serial stream with
//            valid/ready/last. A word offered during the final beat is taken
//            on that same edge so consecutive words stream without a bubble.
// Options  : PISO_PARITY_EN - append an even-parity beat (par_beat/par_bit)
//            after the data beats; ser_last then moves to the parity beat.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module piso_word_sequencer
  import piso_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int SEL_W     = SEL_W_DEF,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] word_q,
  output logic [SEL_W-1:0] sel,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last
`ifdef PISO_PARITY_EN
  ,
  output logic             par_beat,
  output logic             par_bit
`endif
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] word_d;
  logic             at_end;
  logic             beat_acc;
  logic             final_acc;
  logic             load_acc;
  logic             sel_step;

  assign beat_acc   = ser_valid & ser_ready;
  assign final_acc  = beat_acc & ser_last;
  assign load_ready = (state_q == ST_IDLE) | final_acc;
  assign load_acc   = load_valid & load_ready;
  // Parity beats keep the select parked at the end index.
  assign sel_step   = beat_acc & (state_q == ST_SHIFT) & ~at_end;

  piso_sel_counter #(
    .SEL_W     (SEL_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_sel_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load_acc | final_acc),
    .en     (sel_step),
    .sel    (sel),
    .at_end (at_end)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a load on the final accept keeps the stream in SHIFT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load_acc) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (beat_acc && at_end) begin
`ifdef PISO_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = load_acc ? ST_SHIFT : ST_IDLE;
`endif
        end
      end
      ST_PARITY: begin
        if (beat_acc) state_d = load_acc ? ST_SHIFT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: serial framing decoded from the current state.
  always_comb begin
    ser_valid = 1'b0;
    ser_last  = 1'b0;
`ifdef PISO_PARITY_EN
    par_beat  = 1'b0;
`endif
    unique case (state_q)
      ST_SHIFT: begin
        ser_valid = 1'b1;
`ifndef PISO_PARITY_EN
        ser_last  = at_end;
`endif
      end
      ST_PARITY: begin
        ser_valid = 1'b1;
        ser_last  = 1'b1;
`ifdef PISO_PARITY_EN
        par_beat  = 1'b1;
`endif
      end
      default: ;
    endcase
  end

`ifdef PISO_PARITY_EN
  assign par_bit = ^word_q;
`endif

  // Word holding register: only a load handshake changes it.
  always_comb begin
    word_d = word_q;
    if (load_acc) word_d = load_data;
  end

  // Word register driving the mux data inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_piso_word_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_piso_word_sequencer
// Purpose  : Randomized self-checking bench. Two instances (LSB first and MSB
//            first) share all inputs and are compared every cycle against a
//            beat-position reference model; each word is also reassembled
//            from the mux bits.
// Options  : PISO_PARITY_EN - expects the 33-beat framing with parity beat.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_piso_word_sequencer;

`ifdef PISO_PARITY_EN
  localparam int FRAME = 33;
`else
  localparam int FRAME = 32;
`endif

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic [31:0] load_data;
  logic        ser_ready;

  logic        load_ready_a, load_ready_b;
  logic [31:0] word_q_a, word_q_b;
  logic [4:0]  sel_a, sel_b;
  logic        ser_valid_a, ser_valid_b;
  logic        ser_last_a, ser_last_b;
`ifdef PISO_PARITY_EN
  logic        par_beat_a, par_beat_b, par_bit_a, par_bit_b;
`endif

  piso_word_sequencer #(.WIDTH(32), .SEL_W(5), .LSB_FIRST(1)) u_dut_lsb (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready_a),
    .load_data(load_data), .word_q(word_q_a), .sel(sel_a), .ser_valid(ser_valid_a),
    .ser_ready(ser_ready), .ser_last(ser_last_a)
`ifdef PISO_PARITY_EN
    , .par_beat(par_beat_a), .par_bit(par_bit_a)
`endif
  );

  piso_word_sequencer #(.WIDTH(32), .SEL_W(5), .LSB_FIRST(0)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready_b),
    .load_data(load_data), .word_q(word_q_b), .sel(sel_b), .ser_valid(ser_valid_b),
    .ser_ready(ser_ready), .ser_last(ser_last_b)
`ifdef PISO_PARITY_EN
    , .par_beat(par_beat_b), .par_bit(par_bit_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: is a word in flight, which beat of it, and its value.
  bit          m_busy;
  int          m_k;
  logic [31:0] m_word;
  logic [31:0] coll_a, coll_b;
  logic [31:0] send_q[$];
  bit          lv;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_reset_values();
    check("rst_valid_a", 32'(ser_valid_a), 32'd0);
    check("rst_valid_b", 32'(ser_valid_b), 32'd0);
    check("rst_last_a",  32'(ser_last_a),  32'd0);
    check("rst_last_b",  32'(ser_last_b),  32'd0);
    check("rst_word_a",  word_q_a,         32'd0);
    check("rst_word_b",  word_q_b,         32'd0);
    check("rst_sel_a",   32'(sel_a),       32'd0);
    check("rst_sel_b",   32'(sel_b),       32'd31);
    check("rst_ready_a", 32'(load_ready_a), 32'd1);
    check("rst_ready_b", 32'(load_ready_b), 32'd1);
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic cycle(input bit stall, input bit gap);
    bit exp_last, exp_ready, beat_acc, load_acc;
    if (send_q.size() == 0) lv = 1'b0;
    else if (!lv)           lv = !gap || ($urandom_range(0, 1) == 1);
    load_valid = lv;
    load_data  = lv ? send_q[0] : $urandom;
    ser_ready  = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
    #1;
    exp_last  = m_busy && (m_k == FRAME - 1);
    exp_ready = !m_busy || (ser_ready && exp_last);
    check("load_ready_a", 32'(load_ready_a), 32'(exp_ready));
    check("load_ready_b", 32'(load_ready_b), 32'(exp_ready));
    check("ser_valid_a",  32'(ser_valid_a),  32'(m_busy));
    check("ser_valid_b",  32'(ser_valid_b),  32'(m_busy));
    check("ser_last_a",   32'(ser_last_a),   32'(exp_last));
    check("ser_last_b",   32'(ser_last_b),   32'(exp_last));
    check("word_q_a",     word_q_a,          m_word);
    check("word_q_b",     word_q_b,          m_word);
    if (m_busy && m_k < 32) begin
      check("sel_a", 32'(sel_a), 32'(m_k));
      check("sel_b", 32'(sel_b), 32'(31 - m_k));
      check("bit_a", 32'(word_q_a[sel_a]), 32'(m_word[m_k]));
      check("bit_b", 32'(word_q_b[sel_b]), 32'(m_word[31 - m_k]));
    end
`ifdef PISO_PARITY_EN
    check("par_beat_a", 32'(par_beat_a), 32'(m_busy && m_k == 32));
    check("par_beat_b", 32'(par_beat_b), 32'(m_busy && m_k == 32));
    if (m_busy && m_k == 32) begin
      check("par_bit_a", 32'(par_bit_a), 32'(^m_word));
      check("par_bit_b", 32'(par_bit_b), 32'(^m_word));
    end
`endif
    beat_acc = m_busy && ser_ready;
    load_acc = load_valid && exp_ready;
    if (beat_acc) begin
      if (m_k < 32) begin
        coll_a[sel_a] = word_q_a[sel_a];
        coll_b[sel_b] = word_q_b[sel_b];
      end
      if (exp_last) begin
        check("reassembled_a", coll_a, m_word);
        check("reassembled_b", coll_b, m_word);
        m_busy = 1'b0;
      end else begin
        m_k++;
      end
    end
    if (load_acc) begin
      m_word = load_data;
      m_busy = 1'b1;
      m_k    = 0;
      coll_a = '0;
      coll_b = '0;
      void'(send_q.pop_front());
      lv = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit stall, input bit gap);
    for (int i = 0; i < n; i++) cycle(stall, gap);
  endtask

  initial begin
    bit hit;
    rst_n = 1'b0; load_valid = 1'b0; load_data = '0; ser_ready = 1'b0;
    m_busy = 1'b0; m_k = 0; m_word = '0; coll_a = '0; coll_b = '0; lv = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;

    // Single word, consumer always ready, then idle.
    send_q.push_back(32'hA5A5_0F0F);
    run(40, 1'b0, 1'b0);

    // Back-to-back words: second is offered during the first word's final beat.
    send_q.push_back(32'hFFFF_FFFF);
    send_q.push_back(32'h0000_0001);
    run(72, 1'b0, 1'b0);

    // Consumer stalls roughly half the time.
    send_q.push_back(32'h1234_5678);
    run(130, 1'b1, 1'b0);

    send_q.push_back(32'h8000_0000);
    send_q.push_back(32'h0000_0007);
    for (int i = 0; i < 4; i++) send_q.push_back($urandom);
    run(520, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a word.
    send_q.delete();
    lv = 1'b0;
    send_q.push_back(32'hCAFE_F00D);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      cycle(1'b0, 1'b0);
      hit = m_busy && (m_k == 10);
    end
    check("reach_beat10", 32'(hit), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_values();
    m_busy = 1'b0; m_k = 0; m_word = '0; lv = 1'b0;
    load_valid = 1'b0;
    send_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send_q.push_back(32'hDEAD_BEEF);
    run(40, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
